// File: rtl/regfile_mp.sv
// Multi-port register file with an initialisation sweep and per-register
// pending (scoreboard) bits. It has two write ports, NUM_RD combinational
// read ports and same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [NUM_RD-1:0]          busy,
    output logic                       ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                ready_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    pending;

    logic                run;
    logic                wr0, wr1, iss_ok;
    logic [ADDR_W-1:0]   ra;
    logic [DATA_W-1:0]   rd;
    logic                hit0, hit1;

    // rst is synchronous, but outputs must read as "not ready" while it is held,
    // so the registered ready flag is masked by the live reset.
    assign run    = ready_q & ~rst;
    assign ready  = run;
    assign wr0    = run & we0 & ~((ZERO_R0 != 0) && (waddr0 == '0));
    assign wr1    = run & we1 & ~((ZERO_R0 != 0) && (waddr1 == '0));
    assign iss_ok = run & iss_valid & ~((ZERO_R0 != 0) && (iss_addr == '0));

    // Sequencing FSM: sweep every address once in INIT, then stay in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == '1) begin
                state   <= RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // Storage and pending bits: INIT zeroes one entry per cycle; in RUN port 1
    // is applied after port 0 so it wins, and issue is applied after the clears
    // so a same-cycle set survives.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt]     <= '0;
            pending[cnt] <= 1'b0;
        end else begin
            if (wr0) mem[waddr0] <= wdata0;
            if (wr1) mem[waddr1] <= wdata1;
            if (wr0) pending[waddr0] <= 1'b0;
            if (wr1) pending[waddr1] <= 1'b0;
            if (iss_ok) pending[iss_addr] <= 1'b1;
        end
    end

    // Read ports: zero register, then forwarding (port 1 first), then storage.
    always_comb begin
        rdata = '0;
        busy  = '0;
        ra    = '0;
        rd    = '0;
        hit0  = 1'b0;
        hit1  = 1'b0;
        for (int unsigned i = 0; i < unsigned'(NUM_RD); i++) begin
            ra   = raddr[i*ADDR_W +: ADDR_W];
            hit1 = we1 && (waddr1 == ra);
            hit0 = we0 && (waddr0 == ra);
            if (!run) begin
                busy[i] = 1'b1;
            end else if (re[i]) begin
                if ((ZERO_R0 != 0) && (ra == '0))
                    rd = '0;
                else if (hit1)
                    rd = wdata1;
                else if (hit0)
                    rd = wdata0;
                else
                    rd = mem[ra];
                rdata[i*DATA_W +: DATA_W] = rd;
                busy[i] = pending[ra] & ~hit0 & ~hit1;
            end
        end
    end

endmodule
